sqrt_issue_arbiter: RTL and testbench
=====================================

// Module: sqrt_issue_arbiter
// PURPOSE
//  Shares one fixed-latency fxSqrt instance among N_REQ requesters (e.g. per-path vol/discount lanes).
//  Round-robin grants one operand per issue slot, throttles to the unit's issue rate,
//  carries a requester tag alongside the unit pipeline, and steers each result back to its owner.
//  Negative operands never reach the unit: they are issued as zero and flagged on return.
// PARAMETERS
//  WIDTH        fpga_cfg_pkg::FP_WIDTH        operand/result width (signed fixed point)
//  N_REQ        4                             number of requesters, >=2
//  SQRT_LATENCY fpga_cfg_pkg::FP_SQRT_LATENCY cycles from sqrt_valid_in to sqrt_valid_out
//  ISSUE_GAP    1                             minimum cycles between issues (1 = every cycle)
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            asynchronous active-low reset
//  req_valid  in   N_REQ        requester i holds an operand
//  req_a      in   N_REQ*WIDTH  operand of requester i in bits [i*WIDTH +: WIDTH]
//  req_ready  out  N_REQ        one-hot grant; handshake = req_valid[i] & req_ready[i]
//  sqrt_valid_in out 1          to fxSqrt valid_in (registered)
//  sqrt_a     out  WIDTH        to fxSqrt a (registered)
//  sqrt_valid_out in 1          from fxSqrt valid_out
//  sqrt_out   in   WIDTH        from fxSqrt sqrt_out
//  rsp_valid  out  N_REQ        one-hot, one cycle: result for requester i (registered)
//  rsp_data   out  WIDTH        result; 0 when rsp_neg
//  rsp_neg    out  1            operand was negative (MSB set)
//  busy       out  1            any issue in flight
//  err_tag    out  1            sticky: unit valid and tag pipeline disagreed
// BEHAVIOUR
//  Reset: all outputs 0; RR pointer = N_REQ-1 (requester 0 wins first); tags/gap counter cleared.
//  Grant (combinational): if gap_cnt==0, req_ready = one-hot of first i with req_valid[i],
//   searching ptr+1, ptr+2, ... wrapping modulo N_REQ; else req_ready = 0.
//   req_ready depends on req_valid (allowed); requesters must not depend ready->valid.
//  On handshake of i at edge k: ptr <= i; gap_cnt <= ISSUE_GAP-1;
//   cycle k+1: sqrt_valid_in=1, sqrt_a = req_a[i] if MSB=0 else 0; tag {vld=1,id=i,neg} pushed.
//   No handshake: sqrt_valid_in=0, sqrt_a holds last value, tag {vld=0} pushed.
//  gap_cnt decrements to 0 by one per cycle; ISSUE_GAP=1 never blocks.
//  Tag pipe: SQRT_LATENCY-deep shift register, advancing every cycle; output aligned with sqrt_valid_out.
//  Return: at cycle k+1+SQRT_LATENCY, if sqrt_valid_out & tag.vld -> next cycle rsp_valid[id]=1,
//   rsp_data = tag.neg ? 0 : sqrt_out, rsp_neg = tag.neg. Accept-to-rsp_valid = SQRT_LATENCY+2.
//  Mismatch (sqrt_valid_out != tag.vld): err_tag <= 1 (sticky), no rsp_valid that cycle.
//  rsp_data/rsp_neg hold last value when rsp_valid=0. No result backpressure: owner must take it.
//  busy = |tag pipe vld | sqrt_valid_in | |rsp_valid.
//  Simultaneous grant and return in one cycle are independent; full throughput = 1 per ISSUE_GAP.
//  Reset mid-operation: in-flight tags discarded, no rsp_valid after reset; fxSqrt shares rst_n.
//  Width rules: no arithmetic on data; id width = $clog2(N_REQ); gap_cnt width = $clog2(ISSUE_GAP+1).
// TESTING (N_REQ=4, WIDTH=32, QFRAC=16, SQRT_LATENCY=L, ISSUE_GAP=1 unless noted)
//  1 Single: req_valid=4'b0100, req_a[2]=4.0 (0x00040000) -> req_ready=4'b0100, rsp_valid=4'b0100
//    exactly L+2 cycles later, rsp_data = unit output for 4.0 (~2.0), rsp_neg=0.
//  2 Fairness: all four req_valid held high 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in same order.
//  3 Negative: req_a[1]=0xFFFF0000 (-1.0) -> sqrt_a=0, rsp_valid[1]=1, rsp_data=0, rsp_neg=1.
//  4 Throttle: ISSUE_GAP=3, req 0 and 1 held -> sqrt_valid_in high every 3rd cycle, grants alternate.
//  5 Error: force sqrt_valid_out=1 with empty tag pipe -> err_tag=1 and stays 1; no rsp_valid.
//  6 Reset: drop rst_n with 3 ops in flight -> all outputs 0 immediately; none return after release.

Source files
------------

// File: rtl/sqrt_issue_arbiter.sv
// rtl/sqrt_issue_arbiter.sv - round-robin issue arbiter sharing one fixed-latency sqrt unit
module sqrt_issue_arbiter #(
  parameter int WIDTH        = 32,
  parameter int N_REQ        = 4,
  parameter int SQRT_LATENCY = 4,
  parameter int ISSUE_GAP    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   sqrt_valid_in,
  output logic [WIDTH-1:0]       sqrt_a,
  input  logic                   sqrt_valid_out,
  input  logic [WIDTH-1:0]       sqrt_out,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_neg,
  output logic                   busy,
  output logic                   err_tag
);

  localparam int IDW = $clog2(N_REQ);
  localparam int GW  = $clog2(ISSUE_GAP + 1);

  logic [IDW-1:0]          r_ptr;
  logic [GW-1:0]           r_gap;
  logic                    r_vin;
  logic [WIDTH-1:0]        r_a;
  logic [IDW-1:0]          r_iid;
  logic                    r_ineg;
  logic [SQRT_LATENCY-1:0] r_tv;
  logic [IDW-1:0]          r_tid [SQRT_LATENCY];
  logic                    r_tn  [SQRT_LATENCY];
  logic [N_REQ-1:0]        r_rsp_valid;
  logic [WIDTH-1:0]        r_rsp_data;
  logic                    r_rsp_neg;
  logic                    r_err;

  logic                    w_found;
  logic [IDW-1:0]          w_id;
  logic [IDW-1:0]          w_cand;
  logic [WIDTH-1:0]        w_a;
  logic                    w_hs;
  logic                    w_tv;
  logic                    w_ret;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_id    = '0;
    w_cand  = '0;
    w_a     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_id    = w_cand;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (w_id == IDW'(i)) w_a = req_a[i*WIDTH +: WIDTH];
    end
  end

  assign w_hs      = w_found && (r_gap == '0);
  assign req_ready = w_hs ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_id) : '0;

  // Tag output lines up with the unit's valid_out because the pipe is fed from the issue register.
  assign w_tv  = r_tv[SQRT_LATENCY-1];
  assign w_ret = sqrt_valid_out && w_tv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= IDW'(N_REQ - 1);
      r_gap       <= '0;
      r_vin       <= 1'b0;
      r_a         <= '0;
      r_iid       <= '0;
      r_ineg      <= 1'b0;
      r_tv        <= '0;
      for (int i = 0; i < SQRT_LATENCY; i++) begin
        r_tid[i] <= '0;
        r_tn[i]  <= 1'b0;
      end
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_neg   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_vin <= w_hs;
      if (w_hs) begin
        r_ptr  <= w_id;
        r_gap  <= GW'(ISSUE_GAP - 1);
        r_a    <= w_a[WIDTH-1] ? '0 : w_a;
        r_iid  <= w_id;
        r_ineg <= w_a[WIDTH-1];
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end

      r_tv[0]  <= r_vin;
      r_tid[0] <= r_iid;
      r_tn[0]  <= r_ineg;
      for (int i = 1; i < SQRT_LATENCY; i++) begin
        r_tv[i]  <= r_tv[i-1];
        r_tid[i] <= r_tid[i-1];
        r_tn[i]  <= r_tn[i-1];
      end

      r_rsp_valid <= w_ret ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_tid[SQRT_LATENCY-1]) : '0;
      if (w_ret) begin
        r_rsp_data <= r_tn[SQRT_LATENCY-1] ? '0 : sqrt_out;
        r_rsp_neg  <= r_tn[SQRT_LATENCY-1];
      end
      if (sqrt_valid_out != w_tv) r_err <= 1'b1;
    end
  end

  assign sqrt_valid_in = r_vin;
  assign sqrt_a        = r_a;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_neg       = r_rsp_neg;
  assign err_tag       = r_err;
  assign busy          = (|r_tv) | r_vin | (|r_rsp_valid);

endmodule

// File: tb/tb_sqrt_issue_arbiter.sv
// tb/tb_sqrt_issue_arbiter.sv - directed vector bench for sqrt_issue_arbiter
module tb_sqrt_issue_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N-1:0]   req_ready;
  logic           sqrt_valid_in;
  logic [W-1:0]   sqrt_a;
  logic           sqrt_valid_out;
  logic [W-1:0]   sqrt_out;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_neg;
  logic           busy;
  logic           err_tag;
  logic           force_v = 1'b0;

  logic [N-1:0]   g3_req_valid = '0;
  logic [N*W-1:0] g3_req_a = '0;
  logic [N-1:0]   g3_req_ready;
  logic           g3_sqrt_valid_in;
  logic [W-1:0]   g3_sqrt_a;
  logic           g3_sqrt_valid_out;
  logic [N-1:0]   g3_rsp_valid;
  logic [W-1:0]   g3_rsp_data;
  logic           g3_rsp_neg;
  logic           g3_busy;
  logic           g3_err_tag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqrt_issue_arbiter #(.WIDTH(W), .N_REQ(N), .SQRT_LATENCY(L), .ISSUE_GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
    .sqrt_valid_in(sqrt_valid_in), .sqrt_a(sqrt_a), .sqrt_valid_out(sqrt_valid_out),
    .sqrt_out(sqrt_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_neg(rsp_neg),
    .busy(busy), .err_tag(err_tag));

  sqrt_issue_arbiter #(.WIDTH(W), .N_REQ(N), .SQRT_LATENCY(L), .ISSUE_GAP(3)) u_gap3 (
    .clk(clk), .rst_n(rst_n), .req_valid(g3_req_valid), .req_a(g3_req_a), .req_ready(g3_req_ready),
    .sqrt_valid_in(g3_sqrt_valid_in), .sqrt_a(g3_sqrt_a), .sqrt_valid_out(g3_sqrt_valid_out),
    .sqrt_out('0), .rsp_valid(g3_rsp_valid), .rsp_data(g3_rsp_data), .rsp_neg(g3_rsp_neg),
    .busy(g3_busy), .err_tag(g3_err_tag));

  // Q16.16 square root of an unsigned operand, used as the stand-in unit.
  function automatic logic [31:0] isqrt_q16(input logic [31:0] a);
    longint unsigned x, r, t;
    x = {32'd0, a} << 16;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[31:0];
  endfunction

  logic [L-1:0] m_v;
  logic [W-1:0] m_d [L];
  logic [L-1:0] m3_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v  <= '0;
      m3_v <= '0;
      for (int i = 0; i < L; i++) m_d[i] <= '0;
    end else begin
      m_v    <= {m_v[L-2:0], sqrt_valid_in};
      m3_v   <= {m3_v[L-2:0], g3_sqrt_valid_in};
      m_d[0] <= isqrt_q16(sqrt_a);
      for (int i = 1; i < L; i++) m_d[i] <= m_d[i-1];
    end
  end

  assign sqrt_valid_out    = m_v[L-1] | force_v;
  assign sqrt_out          = m_d[L-1];
  assign g3_sqrt_valid_out = m3_v[L-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]        rv;
    logic [3:0][31:0]  a;
    logic [3:0]        ready;
    logic              svi;
    logic [31:0]       sa;
    logic [3:0]        rsp;
    logic [31:0]       data;
    logic              neg;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] va, vb, vf;
    logic [31:0] fair_data [4];
    int g;

    va = {32'h0010_0000, 32'h0004_0000, 32'hFFFF_0000, 32'h0001_0000};
    vb = {32'h0009_0000, 32'h8000_0000, 32'h0004_0000, 32'h0002_4000};
    vf = {32'h0010_0000, 32'h0009_0000, 32'h0004_0000, 32'h0001_0000};
    fair_data = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};

    vt[0] = '{rv:4'b0100, a:va, ready:4'b0100, svi:1'b1, sa:32'h0004_0000, rsp:4'b0100, data:32'h0002_0000, neg:1'b0};
    vt[1] = '{rv:4'b1111, a:va, ready:4'b1000, svi:1'b1, sa:32'h0010_0000, rsp:4'b1000, data:32'h0004_0000, neg:1'b0};
    vt[2] = '{rv:4'b0011, a:va, ready:4'b0001, svi:1'b1, sa:32'h0001_0000, rsp:4'b0001, data:32'h0001_0000, neg:1'b0};
    vt[3] = '{rv:4'b0011, a:va, ready:4'b0010, svi:1'b1, sa:32'h0000_0000, rsp:4'b0010, data:32'h0000_0000, neg:1'b1};
    vt[4] = '{rv:4'b1001, a:vb, ready:4'b1000, svi:1'b1, sa:32'h0009_0000, rsp:4'b1000, data:32'h0003_0000, neg:1'b0};
    vt[5] = '{rv:4'b1001, a:vb, ready:4'b0001, svi:1'b1, sa:32'h0002_4000, rsp:4'b0001, data:32'h0001_8000, neg:1'b0};
    vt[6] = '{rv:4'b0000, a:vb, ready:4'b0000, svi:1'b0, sa:32'h0002_4000, rsp:4'b0000, data:32'h0001_8000, neg:1'b0};
    vt[7] = '{rv:4'b0110, a:vb, ready:4'b0010, svi:1'b1, sa:32'h0004_0000, rsp:4'b0010, data:32'h0002_0000, neg:1'b0};
    vt[8] = '{rv:4'b0100, a:vb, ready:4'b0100, svi:1'b1, sa:32'h0000_0000, rsp:4'b0100, data:32'h0000_0000, neg:1'b1};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {req_ready, sqrt_valid_in, sqrt_a, rsp_valid, rsp_data, rsp_neg, busy, err_tag}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      req_valid = vt[v].rv;
      req_a     = vt[v].a;
      #1;
      chk($sformatf("v%0d_ready", v), req_ready, vt[v].ready);
      @(posedge clk);
      #1;
      req_valid = '0;
      chk($sformatf("v%0d_sqrt_valid_in", v), sqrt_valid_in, vt[v].svi);
      chk($sformatf("v%0d_sqrt_a", v), sqrt_a, vt[v].sa);
      repeat (L) @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_early", v), rsp_valid, 4'b0000);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", v), rsp_valid, vt[v].rsp);
      chk($sformatf("v%0d_rsp_data", v), rsp_data, vt[v].data);
      chk($sformatf("v%0d_rsp_neg", v), rsp_neg, vt[v].neg);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_one_cycle", v), rsp_valid, 4'b0000);
    end
    chk("idle_busy_err", {busy, err_tag}, 2'b00);

    // three issues in flight, then asynchronous reset
    @(negedge clk);
    req_valid = 4'b0111;
    req_a     = va;
    repeat (3) @(negedge clk);
    req_valid = '0;
    #1;
    chk("midop_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {sqrt_valid_in, sqrt_a, rsp_valid, rsp_data, rsp_neg, busy, err_tag}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 2*L + 4; t++) begin
      @(negedge clk);
      #1;
      chk($sformatf("after_reset_rsp_t%0d", t), {rsp_valid, busy}, 5'd0);
    end

    // fairness from fresh pointer
    for (int t = 0; t < 8 + L + 4; t++) begin
      @(negedge clk);
      req_valid = (t < 8) ? 4'b1111 : 4'b0000;
      req_a     = vf;
      #1;
      if (t < 8) chk($sformatf("fair_ready_t%0d", t), req_ready, 4'b0001 << (t % 4));
      g = t - L - 2;
      if (g >= 0 && g < 8) begin
        chk($sformatf("fair_rsp_t%0d", t), rsp_valid, 4'b0001 << (g % 4));
        chk($sformatf("fair_data_t%0d", t), rsp_data, fair_data[g % 4]);
      end else begin
        chk($sformatf("fair_rsp_t%0d", t), rsp_valid, 4'b0000);
      end
    end

    // unit valid with empty tag pipe
    @(negedge clk);
    #1;
    chk("err_before", err_tag, 1'b0);
    @(negedge clk);
    force_v = 1'b1;
    @(negedge clk);
    force_v = 1'b0;
    #1;
    chk("err_set", {err_tag, rsp_valid}, 5'b1_0000);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      chk($sformatf("err_sticky_t%0d", t), {err_tag, rsp_valid}, 5'b1_0000);
    end

    // ISSUE_GAP=3 instance: issues every third cycle, alternating 0 and 1
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      g3_req_valid = 4'b0011;
      g3_req_a     = va;
      #1;
      if (t % 3 == 0)
        chk($sformatf("gap3_ready_t%0d", t), g3_req_ready, ((t / 3) % 2 == 1) ? 4'b0010 : 4'b0001);
      else
        chk($sformatf("gap3_ready_t%0d", t), g3_req_ready, 4'b0000);
      if (t > 0) chk($sformatf("gap3_svi_t%0d", t), g3_sqrt_valid_in, (t % 3 == 1));
    end
    @(negedge clk);
    g3_req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
